// File: rtl/sm_regdump_tx.sv
// sm_regdump_tx: walks the CPU debug register port and streams each register
// as a 5-byte 8N1 UART record {addr, word[31:24], word[23:16], word[15:8], word[7:0]}.
module sm_regdump_tx #(
  parameter int CLK_DIV   = 434,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  localparam int TW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, CAPT, SEND} state_t;
  state_t state, state_nx;
  logic [TW-1:0] timer;
  logic [3:0] bit_idx;
  logic [2:0] byte_idx;
  logic [7:0] sh, byte_nx;
  logic [31:0] word;
  logic bit_end, rec_end, last, tx_nx, busy_nx, done_nx;
  assign bit_end = timer == TW'(CLK_DIV - 1);
  assign last    = regAddr == 5'(LAST_REG);
  assign rec_end = state == SEND && bit_end && bit_idx == 4'd9 && byte_idx == 3'd4;
  // byte_nx is the record byte following the current one
  assign byte_nx = byte_idx == 3'd0 ? word[31:24] :
                   byte_idx == 3'd1 ? word[23:16] :
                   byte_idx == 3'd2 ? word[15:8]  : word[7:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? CAPT : IDLE) :
               state == CAPT ? SEND :
               rec_end       ? (last ? IDLE : CAPT) : SEND;
  // Registered outputs: tx leads with the start bit as CAPT ends, so no gap before SEND
  always_comb begin
    tx_nx   = state == CAPT ? 1'b0 :
              (state != SEND || !bit_end) ? tx :
              bit_idx < 4'd8 ? sh[0] :
              bit_idx == 4'd8 ? 1'b1 : byte_idx == 3'd4;
    busy_nx = state == IDLE ? start : !(rec_end && last);
    done_nx = rec_end && last;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      regAddr  <= 5'(FIRST_REG);
      word     <= '0;
      sh       <= '0;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx    <= tx_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      timer <= (state == SEND && !bit_end) ? timer + 1'b1 : '0;
      if (state == CAPT) begin
        word     <= regData;
        sh       <= {3'b000, regAddr};
        bit_idx  <= '0;
        byte_idx <= '0;
      end else if (state == SEND && bit_end) begin
        if (bit_idx != 4'd9) begin
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx < 4'd8) sh <= {1'b0, sh[7:1]};
        end else if (byte_idx != 3'd4) begin
          bit_idx  <= '0;
          byte_idx <= byte_idx + 1'b1;
          sh       <= byte_nx;
        end else begin
          bit_idx  <= '0;
          byte_idx <= '0;
          regAddr  <= last ? 5'(FIRST_REG) : regAddr + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_sm_regdump_tx.sv
// tb_sm_regdump_tx: directed checks of sm_regdump_tx with CLK_DIV=4, a
// single-register instance (5..5) and a full-range instance (0..31).
module tb_sm_regdump_tx;
  localparam int DIV = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] start_s = 2'b00;
  logic [1:0] tx_w, busy_w, done_w;
  logic [4:0] addr0, addr1;
  logic [31:0] rd0, rd1;
  logic [31:0] mem [32];
  bit poke_en = 1'b0;
  int vectors = 0, miscompares = 0;
  assign rd0 = addr0 == 5'd5 ? 32'h12345678 : 32'hDEADBEEF;
  assign rd1 = mem[addr1];
  always #5 clk = ~clk;
  sm_regdump_tx #(.CLK_DIV(DIV), .FIRST_REG(5), .LAST_REG(5)) u_one (
    .clk(clk), .rst(rst), .start(start_s[0]), .regAddr(addr0), .regData(rd0),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  sm_regdump_tx #(.CLK_DIV(DIV)) u_full (
    .clk(clk), .rst(rst), .start(start_s[1]), .regAddr(addr1), .regData(rd1),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // UART receiver: entered on the first low cycle of a start bit, samples mid-bit
  task automatic rx_frame(input int g, output logic [7:0] b, output bit ok);
    repeat (DIV / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      b[i] = tx_w[g];
    end
    repeat (DIV) @(negedge clk);
    ok = tx_w[g];
  endtask
  logic [7:0] rx0 [16];
  logic [7:0] rx1 [1024];
  logic [7:0] b0, b1;
  bit ok0, ok1;
  int n0 = 0, n1 = 0, fe0 = 0, fe1 = 0;
  always begin
    @(negedge clk);
    if (!rst && tx_w[0] === 1'b0) begin
      rx_frame(0, b0, ok0);
      if (n0 < 16) rx0[n0] = b0;
      n0++;
      if (!ok0) fe0++;
    end
  end
  always begin
    @(negedge clk);
    if (!rst && tx_w[1] === 1'b0) begin
      rx_frame(1, b1, ok1);
      if (n1 < 1024) rx1[n1] = b1;
      n1++;
      if (!ok1) fe1++;
    end
  end
  task automatic run_dump(input int g, input int restart_at, input int budget,
                          output int bcyc, output int first_low, output int dones);
    int n;
    bcyc = 0; first_low = -1; dones = 0; n = 0;
    @(negedge clk);
    start_s[g] = 1'b1;
    do begin
      @(negedge clk);
      n++;
      start_s[g] = (n == restart_at);
      if (busy_w[g]) bcyc++;
      if (!tx_w[g] && first_low < 0) first_low = n;
      if (done_w[g]) dones++;
      if (poke_en && addr1 == 5'd7 && !tx_w[1]) mem[7] = 32'h55555555;
    end while ((busy_w[g] || n < 2) && n < budget);
    start_s[g] = 1'b0;
    chk($sformatf("dump%0d_in_budget", g), 32'(n < budget), 1);
    @(negedge clk);
    chk($sformatf("dump%0d_done_low_after", g), 32'(done_w[g]), 0);
  endtask
  task automatic check_full(input int base, input logic [31:0] w7);
    int i;
    chk("full_byte_count", n1 - base, 160);
    for (int a = 0; a < 32; a++) begin
      i = base + 5 * a;
      chk($sformatf("rec%0d_addr", a), 32'(rx1[i]), a);
      chk($sformatf("rec%0d_word", a), {rx1[i+1], rx1[i+2], rx1[i+3], rx1[i+4]},
          a == 7 ? w7 : {4{8'(a)}});
    end
  endtask
  logic [7:0] exp1 [5] = '{8'h05, 8'h12, 8'h34, 8'h56, 8'h78};
  int bc, fl, dn, cnt, base;
  initial begin
    for (int a = 0; a < 32; a++) mem[a] = {4{8'(a)}};
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_w[1]), 1);
    chk("rst_busy", 32'(busy_w[1]), 0);
    chk("rst_done", 32'(done_w[1]), 0);
    chk("rst_addr", 32'(addr1), 0);
    rst = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_w != 2'b11) cnt++;
    end
    chk("idle_tx_low_cycles", cnt, 0);
    run_dump(0, 0, 1000, bc, fl, dn);
    chk("one_busy_cycles", bc, 201);
    chk("one_first_low", fl, 2);
    chk("one_done_pulses", dn, 1);
    chk("one_byte_count", n0, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("one_byte%0d", k), 32'(rx0[k]), 32'(exp1[k]));
    chk("one_addr_end", 32'(addr0), 5);
    base = n1;
    run_dump(1, 0, 8000, bc, fl, dn);
    chk("full_busy_cycles", bc, 6432);
    chk("full_first_low", fl, 2);
    chk("full_done_pulses", dn, 1);
    chk("full_addr_end", 32'(addr1), 0);
    check_full(base, 32'h07070707);
    mem[7] = 32'hAAAAAAAA;
    poke_en = 1'b1;
    base = n1;
    run_dump(1, 50, 8000, bc, fl, dn);
    poke_en = 1'b0;
    chk("snap_busy_cycles", bc, 6432);
    chk("snap_done_pulses", dn, 1);
    check_full(base, 32'hAAAAAAAA);
    mem[7] = 32'h07070707;
    @(negedge clk);
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    repeat (901) @(negedge clk);
    chk("mid_addr", 32'(addr1), 4);
    chk("mid_tx_d3", 32'(tx_w[1]), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(tx_w[1]), 1);
    chk("mid_rst_busy", 32'(busy_w[1]), 0);
    chk("mid_rst_done", 32'(done_w[1]), 0);
    chk("mid_rst_addr", 32'(addr1), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (!tx_w[1] || busy_w[1]) cnt++;
    end
    chk("post_rst_idle", cnt, 0);
    base = n1;
    run_dump(1, 0, 8000, bc, fl, dn);
    chk("clean_busy_cycles", bc, 6432);
    chk("clean_first_low", fl, 2);
    check_full(base, 32'h07070707);
    chk("frame_errors_one", fe0, 0);
    chk("frame_errors_full", fe1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
